// File: rtl/block_refill_memory_pkg.sv
// block_refill_memory_pkg
//   Shared definitions for the cache block-fill path: word/block geometry,
//   the responder state encoding, the latched fetch context and a helper
//   that maps a block offset to its bit position in the 128-bit line.
package block_refill_memory_pkg;
   localparam int WORD_SIZE   = 32;
   localparam int WORD_COUNT  = 4;
   localparam int OFFSET_SIZE = 2;
   localparam int ADDR_WIDTH  = 15;
   localparam int BLOCK_WIDTH = WORD_SIZE * WORD_COUNT;
   localparam int BASE_WIDTH  = ADDR_WIDTH - OFFSET_SIZE;

   typedef enum logic [1:0] {IDLE, FETCH, DONE} state_t;

   // Fetch context captured when a block request is accepted.
   typedef struct packed {
      logic [BASE_WIDTH-1:0]  base;
      logic [OFFSET_SIZE-1:0] start;
   } fetch_req_t;

   // LSB of word slot 'off' inside a block line (word w at [32w+31:32w]).
   function automatic int unsigned slot_lsb(input logic [OFFSET_SIZE-1:0] off);
      return int'(off) * WORD_SIZE;
   endfunction
endpackage

// File: rtl/memory_array.sv
// memory_array
//   Single-port 2^AW x DW backing store: synchronous write, combinational
//   read on the same address. Not reset; content is preloaded with
//   mem[i] = i so fetches return recognisable data.
//   clk   : clock
//   we    : write enable, mem[addr] <= wdata on the rising edge
//   addr  : word address (shared by read and write)
//   wdata : write data
//   rdata : mem[addr], combinational
module memory_array
   import block_refill_memory_pkg::*;
#(
   parameter int AW = ADDR_WIDTH,
   parameter int DW = WORD_SIZE
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] addr,
   input  logic [DW-1:0] wdata,
   output logic [DW-1:0] rdata
);
   logic [DW-1:0] mem [0:(1<<AW)-1];

   // Initial content only; the array itself is never reset.
   initial begin
      for (int i = 0; i < (1 << AW); i++) mem[i] = DW'(i);
   end

   always_ff @(posedge clk) begin
      if (we) mem[addr] <= wdata;
   end

   assign rdata = mem[addr];
endmodule

// File: rtl/block_refill_memory.sv
// block_refill_memory
//   Main-memory responder for the data cache block fill. A request latches
//   the block base, then reads the four words of the block one every
//   LATENCY cycles, streams each word (wordValid/wordOut/wordOffset) and
//   assembles them in dataOut; blockValid pulses once the line is complete.
//   Single-word writes are accepted only while idle.
//   Optional build macro: CRITICAL_WORD_FIRST_EN -- capture starts at the
//   requested word and wraps mod 4; otherwise order is always 0,1,2,3.
//   Ports:
//     clk, rst            : clock, synchronous active-high reset
//     address, req, wr    : word address, block request, single-word write
//     wrData              : write data
//     busy                : high while not idle
//     wordValid/wordOut/wordOffset : per-word stream
//     blockValid/dataOut  : complete-line pulse and assembled line
module block_refill_memory
   import block_refill_memory_pkg::*;
#(
   parameter int LATENCY = 2   // cycles per word, must be >= 1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [ADDR_WIDTH-1:0]  address,
   input  logic                   req,
   input  logic                   wr,
   input  logic [WORD_SIZE-1:0]   wrData,
   output logic                   busy,
   output logic                   wordValid,
   output logic [WORD_SIZE-1:0]   wordOut,
   output logic [OFFSET_SIZE-1:0] wordOffset,
   output logic                   blockValid,
   output logic [BLOCK_WIDTH-1:0] dataOut
);
   localparam int              LAT_W      = (LATENCY > 1) ? $clog2(LATENCY) : 1;
   localparam logic [LAT_W-1:0] LAT_RELOAD = LAT_W'(LATENCY - 1);

   state_t                 state;
   fetch_req_t             fr;
   logic [LAT_W-1:0]       latCnt;
   logic [1:0]             cnt;
   logic [OFFSET_SIZE-1:0] off;
   logic                   mem_we;
   logic [ADDR_WIDTH-1:0]  mem_addr;
   logic [WORD_SIZE-1:0]   mem_rdata;

`ifdef CRITICAL_WORD_FIRST_EN
   // 2-bit add wraps the offset within the block; base never moves.
   assign off = fr.start + cnt;
`else
   logic unused_start;
   assign unused_start = ^fr.start;
   assign off          = cnt;
`endif

   // The single port is owned by the write path while idle and by the
   // fetch sequencer otherwise, so a write+req in the same cycle lands
   // before any word of that fetch is read.
   assign mem_we   = (state == IDLE) && wr;
   assign mem_addr = (state == IDLE) ? address : {fr.base, off};
   assign busy     = (state != IDLE);

   memory_array #(.AW(ADDR_WIDTH), .DW(WORD_SIZE)) u_mem (
      .clk   (clk),
      .we    (mem_we),
      .addr  (mem_addr),
      .wdata (wrData),
      .rdata (mem_rdata)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         fr         <= '0;
         latCnt     <= '0;
         cnt        <= '0;
         wordValid  <= 1'b0;
         wordOut    <= '0;
         wordOffset <= '0;
         blockValid <= 1'b0;
         dataOut    <= '0;
      end else begin
         wordValid  <= 1'b0;
         blockValid <= 1'b0;
         case (state)
            IDLE: begin
               if (req) begin
                  fr.base  <= address[ADDR_WIDTH-1:OFFSET_SIZE];
                  fr.start <= address[OFFSET_SIZE-1:0];
                  latCnt   <= LAT_RELOAD;
                  cnt      <= '0;
                  state    <= FETCH;
               end
            end
            FETCH: begin
               if (latCnt != '0) begin
                  latCnt <= latCnt - 1'b1;
               end else begin
                  // Slots are overwritten in place; stale words from the
                  // previous line remain until their slot is captured.
                  dataOut[slot_lsb(off) +: WORD_SIZE] <= mem_rdata;
                  wordValid  <= 1'b1;
                  wordOut    <= mem_rdata;
                  wordOffset <= off;
                  cnt        <= cnt + 1'b1;
                  latCnt     <= LAT_RELOAD;
                  if (cnt == 2'd3) begin
                     // blockValid is high for the single DONE cycle.
                     blockValid <= 1'b1;
                     state      <= DONE;
                  end
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_block_refill_memory.sv
// tb_block_refill_memory
//   Two responders (LATENCY=2 and LATENCY=1) driven by directed and random
//   fetch/write traffic, compared cycle by cycle against a word-array model.
module tb_block_refill_memory;
   import block_refill_memory_pkg::*;

   localparam int NDUT = 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                   rst        [NDUT];
   logic                   req        [NDUT];
   logic                   wr         [NDUT];
   logic [ADDR_WIDTH-1:0]  address    [NDUT];
   logic [WORD_SIZE-1:0]   wrData     [NDUT];
   logic                   busy       [NDUT];
   logic                   wordValid  [NDUT];
   logic [WORD_SIZE-1:0]   wordOut    [NDUT];
   logic [OFFSET_SIZE-1:0] wordOffset [NDUT];
   logic                   blockValid [NDUT];
   logic [BLOCK_WIDTH-1:0] dataOut    [NDUT];

   block_refill_memory #(.LATENCY(2)) u_dut0 (
      .clk(clk), .rst(rst[0]), .address(address[0]), .req(req[0]), .wr(wr[0]),
      .wrData(wrData[0]), .busy(busy[0]), .wordValid(wordValid[0]),
      .wordOut(wordOut[0]), .wordOffset(wordOffset[0]),
      .blockValid(blockValid[0]), .dataOut(dataOut[0])
   );

   block_refill_memory #(.LATENCY(1)) u_dut1 (
      .clk(clk), .rst(rst[1]), .address(address[1]), .req(req[1]), .wr(wr[1]),
      .wrData(wrData[1]), .busy(busy[1]), .wordValid(wordValid[1]),
      .wordOut(wordOut[1]), .wordOffset(wordOffset[1]),
      .blockValid(blockValid[1]), .dataOut(dataOut[1])
   );

   // Reference memory: plain word array per instance.
   logic [31:0] ref_mem [NDUT][32768];
   int n_chk  = 0;
   int n_pass = 0;

   function automatic int lat_of(input int d);
      return (d == 0) ? 2 : 1;
   endfunction

   // Offset of the j-th captured word of a block requested at 'start'.
   function automatic int exp_off(input int start, input int j);
`ifdef CRITICAL_WORD_FIRST_EN
      return (start + j) % 4;
`else
      return j + 0 * start;
`endif
   endfunction

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   task automatic check_zero(input int d, input string tag);
      check($sformatf("d%0d %s busy", d, tag), busy[d], 0);
      check($sformatf("d%0d %s wordValid", d, tag), wordValid[d], 0);
      check($sformatf("d%0d %s blockValid", d, tag), blockValid[d], 0);
      check($sformatf("d%0d %s wordOut", d, tag), wordOut[d], 0);
      check($sformatf("d%0d %s wordOffset", d, tag), wordOffset[d], 0);
      check($sformatf("d%0d %s dataOut", d, tag), dataOut[d], 0);
   endtask

   task automatic idle_wr(input int d, input logic [14:0] a, input logic [31:0] wd);
      wr[d] = 1'b1; address[d] = a; wrData[d] = wd; req[d] = 1'b0;
      @(posedge clk); @(negedge clk);
      wr[d] = 1'b0;
      ref_mem[d][a] = wd;
      check($sformatf("d%0d wr busy", d), busy[d], 0);
      check($sformatf("d%0d wr wordValid", d), wordValid[d], 0);
   endtask

   // One block fetch observed from the accepting edge k through k+4L+1.
   //   with_wr: write wd to a in the request cycle
   //   wr_mid : write mid_a during FETCH (must be ignored)
   //   hold   : keep req high throughout (must be ignored until idle)
   //   abort  : reset right after the 2nd wordValid
   task automatic fetch(input int d, input logic [14:0] a, input bit with_wr,
                        input logic [31:0] wd, input bit wr_mid, input logic [14:0] mid_a,
                        input bit hold, input bit abort);
      int L, base, start, j, o;
      bit wv;
      logic [127:0] blk;
      L     = lat_of(d);
      base  = int'(a) >> 2;
      start = int'(a) & 3;
      req[d] = 1'b1; address[d] = a; wr[d] = with_wr; wrData[d] = wd;
      if (with_wr) ref_mem[d][a] = wd;
      for (int w = 0; w < 4; w++) blk[32*w +: 32] = ref_mem[d][base*4 + w];
      @(posedge clk); @(negedge clk);
      if (!hold) req[d] = 1'b0;
      wr[d] = 1'b0;
      check($sformatf("d%0d a%h e0 busy", d, a), busy[d], 1);
      check($sformatf("d%0d a%h e0 wordValid", d, a), wordValid[d], 0);
      for (int e = 1; e <= 4*L + 1; e++) begin
         if (wr_mid && e == 1) begin
            wr[d] = 1'b1; address[d] = mid_a; wrData[d] = $urandom;
         end else begin
            wr[d] = 1'b0;
         end
         @(posedge clk); @(negedge clk);
         wv = (e % L == 0) && (e <= 4*L);
         check($sformatf("d%0d a%h e%0d wordValid", d, a, e), wordValid[d], wv);
         if (wv) begin
            j = e / L - 1;
            o = exp_off(start, j);
            check($sformatf("d%0d a%h e%0d wordOffset", d, a, e), wordOffset[d], o);
            check($sformatf("d%0d a%h e%0d wordOut", d, a, e), wordOut[d], ref_mem[d][base*4 + o]);
         end
         check($sformatf("d%0d a%h e%0d blockValid", d, a, e), blockValid[d], e == 4*L);
         check($sformatf("d%0d a%h e%0d busy", d, a, e), busy[d], e <= 4*L);
         if (e == 4*L) check($sformatf("d%0d a%h dataOut", d, a), dataOut[d], blk);
         if (abort && e == 2*L) begin
            req[d] = 1'b0; wr[d] = 1'b0; rst[d] = 1'b1;
            @(posedge clk); @(negedge clk);
            rst[d] = 1'b0;
            check_zero(d, "abort");
            for (int c = 0; c < 2*L + 2; c++) begin
               @(posedge clk); @(negedge clk);
               check($sformatf("d%0d post-abort blockValid c%0d", d, c), blockValid[d], 0);
               check($sformatf("d%0d post-abort busy c%0d", d, c), busy[d], 0);
            end
            return;
         end
      end
      if (!hold) req[d] = 1'b0;
   endtask

   initial begin
      for (int d = 0; d < NDUT; d++) begin
         for (int i = 0; i < 32768; i++) ref_mem[d][i] = 32'(i);
         rst[d] = 1'b1; req[d] = 1'b0; wr[d] = 1'b0; address[d] = '0; wrData[d] = '0;
      end
      repeat (2) @(posedge clk);
      @(negedge clk);
      for (int d = 0; d < NDUT; d++) begin
         rst[d] = 1'b0;
         check_zero(d, "reset");
      end

      for (int d = 0; d < NDUT; d++) begin
         fetch(d, 15'h0014, 0, 0, 0, 0, 0, 0);
         fetch(d, 15'h7FFE, 0, 0, 0, 0, 0, 0);
         // write together with req: new data must come back in slot 1
         fetch(d, 15'h0021, 1, 32'hDEADBEEF, 1, 15'h0022, 0, 0);
         check($sformatf("d%0d slot1 wr+req", d), dataOut[d][63:32], 32'hDEADBEEF);
         fetch(d, 15'h0020, 0, 0, 0, 0, 0, 0);
         check($sformatf("d%0d slot2 after ignored wr", d), dataOut[d][95:64], 32'h22);
         // req held high: must refetch only once the responder is idle
         fetch(d, 15'h0043, 0, 0, 0, 0, 1, 0);
         fetch(d, 15'h0045, 0, 0, 0, 0, 0, 0);
         fetch(d, 15'h0101, 0, 0, 0, 0, 0, 1);
         fetch(d, 15'h0102, 0, 0, 0, 0, 0, 0);
      end

      for (int it = 0; it < 60; it++) begin
         int d;
         logic [14:0] a, ma;
         d  = int'($urandom_range(0, 1));
         a  = 15'($urandom);
         ma = {a[14:2], 2'($urandom)};
         if ($urandom_range(0, 3) == 0) begin
            idle_wr(d, {a[14:2], 2'($urandom)}, $urandom);
         end else begin
            fetch(d, a, 1'($urandom), $urandom, 1'($urandom), ma,
                  ($urandom_range(0, 5) == 0), ($urandom_range(0, 7) == 0));
            req[d] = 1'b0;
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/block_refill_memory.md
# block_refill_memory

Main-memory responder for the direct-mapped data cache: on a block request it reads the four 32-bit words of the addressed 4-word block from a 32K-word backing array, one word every LATENCY cycles. It assembles them into the 128-bit line format the cache writes on a refill, and streams each word as it arrives so the cache can forward it early. It is the supply end of the cache's block-fill path and also accepts single-word writes.

## Interface
- WORD_SIZE, 32, bits per word
- WORD_COUNT, 4, words per block
- ADDR_WIDTH, 15, word-address width (2^15 words)
- LATENCY, 2, cycles per word access, must be >= 1
- clk  input  1  clock; all state changes on rising edge
- rst  input  1  synchronous, active-high reset
- address  input  ADDR_WIDTH  word address; [14:2] block, [1:0] offset
- req  input  1  block fetch request, sampled only in IDLE
- wr  input  1  single-word write, sampled only in IDLE
- wrData  input  WORD_SIZE  write data
- busy  output  1  high whenever state != IDLE
- wordValid  output  1  one-cycle pulse per captured word
- wordOut  output  WORD_SIZE  word captured with wordValid
- wordOffset  output  2  block offset of wordOut
- blockValid  output  1  one-cycle pulse: dataOut holds complete block
- dataOut  output  WORD_COUNT*WORD_SIZE  block; word w at [32w+31:32w]

## Operation
- States: IDLE, FETCH, DONE.
- IDLE, wr=1: mem[address] <= wrData the same edge. Writes in FETCH/DONE are ignored.
- IDLE, req=1:
  - Latch base = address[14:2] and start = address[1:0].
  - Load latCnt = LATENCY-1 and cnt = 0, then go to FETCH.
  - If wr is high in the same cycle, the write is performed first and the fetch returns the new data.
- FETCH, each edge:
  - latCnt != 0: latCnt--.
  - latCnt == 0: read mem[{base, off}], write it into dataOut slot off, pulse wordValid with wordOut/wordOffset, cnt++, reload latCnt.
  - Capture of the 4th word (cnt==3) goes to DONE.
- DONE: blockValid=1 for exactly one cycle, then IDLE.
- req is ignored outside IDLE. There is no queuing, so the requester waits for busy=0.
- off order without the macro is 0,1,2,3.
- dataOut persists until the next capture overwrites a slot. Slots are updated in place and not cleared at request start.
- Backing array is not reset; simulation initial content is mem[i] = i (zero-extended).
- rst: state IDLE, busy/wordValid/blockValid = 0, wordOut/wordOffset/dataOut = 0, counters = 0. A fetch in flight is aborted with no blockValid. Array contents are retained.

## Timing
- req sampled at edge k: busy high from k.
- Word j captured at edge k+(j+1)*LATENCY, so wordValid is high in the cycle after it.
- blockValid high in the cycle after edge k+4*LATENCY; busy low after edge k+4*LATENCY+1.
- Next req accepted at edge k+4*LATENCY+2 at earliest. With LATENCY=2: blockValid after edge k+8.
- Write: one cycle, busy stays 0.
- Offset wrap: off = (start + cnt) mod 4, 2-bit arithmetic. The block base never increments.

## Configuration
- CRITICAL_WORD_FIRST_EN defined: capture order starts at start and wraps (start, start+1, ... mod 4), so the first wordValid carries the requested word.
- Undefined: order is always 0,1,2,3 and start is unused.
- dataOut layout, latency and blockValid timing are identical in both builds.

## Structure
- Shared package: WORD_SIZE, WORD_COUNT, OFFSET_SIZE=2, ADDR_WIDTH, the state enum (IDLE/FETCH/DONE), and a block-slot index helper. These are shared with the cache.
- One sub-module, memory_array: single-port 2^ADDR_WIDTH x WORD_SIZE storage with a synchronous write and combinational read. It holds the initial-content loop.
- The controller FSM, counters and block assembly stay in block_refill_memory.

## Test plan
- Reset, then req with address=0x0014, LATENCY=2 -> wordValid after edges k+2,4,6,8 with wordOut 0x14,0x15,0x16,0x17. blockValid after k+8 with dataOut = {0x17,0x16,0x15,0x14}.
- CRITICAL_WORD_FIRST_EN, address=0x7FFE -> wordOffset sequence 2,3,0,1 with words 0x7FFE,0x7FFF,0x7FFC,0x7FFD. dataOut = {0x7FFF,0x7FFE,0x7FFD,0x7FFC}.
- wr address=0x0021 wrData=0xDEADBEEF together with req -> returned block slot 1 = 0xDEADBEEF. A wr during FETCH to 0x0022 leaves mem unchanged on a later fetch.
- A second req while busy -> ignored, with exactly one blockValid. req held high through DONE -> new fetch starts only at the first IDLE edge.
- rst asserted after the 2nd wordValid -> all outputs 0 next cycle, no blockValid, busy=0. A new fetch then completes normally.
- LATENCY=1 -> wordValid on 4 consecutive cycles, blockValid after edge k+4.
